// File: rtl/phys_reg_file.sv
// Physical register file with a per-register ready scoreboard.
// Execute writebacks store data and set ready; rename allocations clear ready.
// Operand reads are combinational and see a same-cycle writeback through a bypass.
// Preg 0 is hardwired to zero and is always ready.
module phys_reg_file #(
    parameter int unsigned NUM_PREGS    = 64,
    parameter int unsigned NUM_RD_PORTS = 4,
    parameter int unsigned NUM_ARCH     = 32,
    localparam int unsigned PREG_W      = $clog2(NUM_PREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ex_valid,
    input  logic [31:0]                    ex_dst_val,
    input  logic [PREG_W-1:0]              ex_dst_index,
    input  logic                           alloc_valid,
    input  logic [PREG_W-1:0]              alloc_index,
    input  logic [NUM_RD_PORTS*PREG_W-1:0] rd_index,
    output logic [NUM_RD_PORTS*32-1:0]     rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_ready,
    output logic                           err_dbl_write
);

    logic [31:0]          data_q [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_d;
    logic                 err_q;
    logic                 err_d;

    // Writes and allocs aimed at preg 0 are dropped entirely.
    logic wr_en;
    logic alloc_en;
    assign wr_en    = ex_valid && (ex_dst_index != '0);
    assign alloc_en = alloc_valid && (alloc_index != '0);

    // Next-state scoreboard and error: alloc is applied after the write so it wins on a tie.
    always_comb begin
        ready_d = ready_q;
        err_d   = err_q;
        if (wr_en) begin
            ready_d[ex_dst_index] = 1'b1;
            // Writing a preg that is already ready means a duplicate writeback, unless
            // the same cycle re-allocates it.
            if (ready_q[ex_dst_index] && !(alloc_en && (alloc_index == ex_dst_index))) begin
                err_d = 1'b1;
            end
        end
        if (alloc_en) begin
            ready_d[alloc_index] = 1'b0;
        end
    end

    // State update; reset discards any same-cycle write or alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < NUM_PREGS; p++) begin
                data_q[p]  <= '0;
                ready_q[p] <= (p < NUM_ARCH);
            end
            err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q[ex_dst_index] <= ex_dst_val;
            end
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign err_dbl_write = err_q;

    // Independent read ports: preg 0 first, then writeback bypass, then storage.
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
        logic [PREG_W-1:0] r;
        logic              is_zero;
        logic              byp;
        assign r       = rd_index[i*PREG_W +: PREG_W];
        assign is_zero = (r == '0);
        assign byp     = ex_valid && (ex_dst_index == r);
        assign rd_data[i*32 +: 32] = is_zero ? 32'h0 : (byp ? ex_dst_val : data_q[r]);
        assign rd_ready[i]         = is_zero || byp || ready_q[r];
    end

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed self-checking bench for phys_reg_file (default parameters).
module tb_phys_reg_file;

    localparam int PREG_W = 6;
    localparam int NPORTS = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ex_valid;
    logic [31:0]              ex_dst_val;
    logic [PREG_W-1:0]        ex_dst_index;
    logic                     alloc_valid;
    logic [PREG_W-1:0]        alloc_index;
    logic [NPORTS*PREG_W-1:0] rd_index;
    logic [NPORTS*32-1:0]     rd_data;
    logic [NPORTS-1:0]        rd_ready;
    logic                     err_dbl_write;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    phys_reg_file dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_dst_val   (ex_dst_val),
        .ex_dst_index (ex_dst_index),
        .alloc_valid  (alloc_valid),
        .alloc_index  (alloc_index),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .err_dbl_write(err_dbl_write)
    );

    // Advance one rising edge, then settle inputs 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_dst_val   = '0;
        ex_dst_index = '0;
        alloc_valid  = 1'b0;
        alloc_index  = '0;
    endtask

    task automatic set_rd(input int a, input int b, input int c, input int d);
        rd_index[0*PREG_W +: PREG_W] = PREG_W'(a);
        rd_index[1*PREG_W +: PREG_W] = PREG_W'(b);
        rd_index[2*PREG_W +: PREG_W] = PREG_W'(c);
        rd_index[3*PREG_W +: PREG_W] = PREG_W'(d);
    endtask

    task automatic test_reset();
        idle_inputs();
        set_rd(5, 40, 0, 31);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'h0 || rd_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_p5: data=%h ready=%b want 0/1", rd_data[0 +: 32], rd_ready[0]);
        end
        n_cmp++;
        if (rd_data[32 +: 32] !== 32'h0 || rd_ready[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_p40: data=%h ready=%b want 0/0", rd_data[32 +: 32], rd_ready[1]);
        end
        n_cmp++;
        if (rd_ready[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_p31: ready=%b want 1", rd_ready[3]);
        end
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: err=%b want 0", err_dbl_write);
        end
    endtask

    task automatic test_alloc_write();
        // Cycle 1: allocate 40 (already not ready; stays not ready).
        tick();
        set_rd(40, 40, 40, 40);
        alloc_valid = 1'b1;
        alloc_index = 6'd40;
        tick();
        // Cycle 2: no activity, still not ready.
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL alloc_c2_ready: ready=%b want 0", rd_ready[0]);
        end
        tick();
        // Cycle 3: writeback, bypass visible immediately.
        ex_valid     = 1'b1;
        ex_dst_index = 6'd40;
        ex_dst_val   = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_c3: data=%h ready=%b want deadbeef/1",
                     rd_data[0 +: 32], rd_ready[0]);
        end
        tick();
        // Cycle 4: value comes from storage.
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_data[96 +: 32] !== 32'hDEADBEEF || rd_ready[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL stored_c4: data=%h ready=%b want deadbeef/1",
                     rd_data[96 +: 32], rd_ready[3]);
        end
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL alloc_write_err: err=%b want 0", err_dbl_write);
        end
    endtask

    task automatic test_preg0();
        set_rd(0, 0, 0, 0);
        ex_valid     = 1'b1;
        ex_dst_index = 6'd0;
        ex_dst_val   = 32'h1234;
        alloc_valid  = 1'b1;
        alloc_index  = 6'd0;
        #1;
        for (int i = 0; i < NPORTS; i++) begin
            n_cmp++;
            if (rd_data[i*32 +: 32] !== 32'h0 || rd_ready[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL preg0_same port%0d: data=%h ready=%b want 0/1",
                         i, rd_data[i*32 +: 32], rd_ready[i]);
            end
        end
        tick();
        idle_inputs();
        #1;
        for (int i = 0; i < NPORTS; i++) begin
            n_cmp++;
            if (rd_data[i*32 +: 32] !== 32'h0 || rd_ready[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL preg0_next port%0d: data=%h ready=%b want 0/1",
                         i, rd_data[i*32 +: 32], rd_ready[i]);
            end
        end
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL preg0_err: err=%b want 0", err_dbl_write);
        end
    endtask

    task automatic test_same_cycle();
        set_rd(41, 40, 0, 0);
        ex_valid     = 1'b1;
        ex_dst_index = 6'd41;
        ex_dst_val   = 32'h55;
        alloc_valid  = 1'b1;
        alloc_index  = 6'd41;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'h55 || rd_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_41: data=%h ready=%b want 00000055/0",
                     rd_data[0 +: 32], rd_ready[0]);
        end
        n_cmp++;
        if (rd_data[32 +: 32] !== 32'hDEADBEEF || rd_ready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cycle_40_kept: data=%h ready=%b want deadbeef/1",
                     rd_data[32 +: 32], rd_ready[1]);
        end
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_err: err=%b want 0", err_dbl_write);
        end
    endtask

    task automatic test_dbl_write();
        set_rd(7, 7, 0, 0);
        ex_valid     = 1'b1;
        ex_dst_index = 6'd7;
        ex_dst_val   = 32'h1;
        #1;
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL dbl_pre_edge_err: err=%b want 0", err_dbl_write);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (err_dbl_write !== 1'b1) begin
            n_bad++;
            $display("FAIL dbl_err_set: err=%b want 1", err_dbl_write);
        end
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'h1 || rd_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL dbl_data7: data=%h ready=%b want 00000001/1",
                     rd_data[0 +: 32], rd_ready[0]);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (err_dbl_write !== 1'b1) begin
            n_bad++;
            $display("FAIL dbl_err_sticky: err=%b want 1", err_dbl_write);
        end
    endtask

    task automatic test_bypass_reset();
        set_rd(40, 40, 40, 40);
        ex_valid     = 1'b1;
        ex_dst_index = 6'd40;
        ex_dst_val   = 32'hA5A5A5A5;
        #1;
        for (int i = 0; i < NPORTS; i++) begin
            n_cmp++;
            if (rd_data[i*32 +: 32] !== 32'hA5A5A5A5 || rd_ready[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL bypass4 port%0d: data=%h ready=%b want a5a5a5a5/1",
                         i, rd_data[i*32 +: 32], rd_ready[i]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'h0 || rd_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_drop_40: data=%h ready=%b want 0/0", rd_data[0 +: 32], rd_ready[0]);
        end
        n_cmp++;
        if (err_dbl_write !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_clears_err: err=%b want 0", err_dbl_write);
        end
        set_rd(7, 41, 0, 0);
        #1;
        n_cmp++;
        if (rd_data[0 +: 32] !== 32'h0 || rd_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_p7: data=%h ready=%b want 0/1", rd_data[0 +: 32], rd_ready[0]);
        end
        n_cmp++;
        if (rd_data[32 +: 32] !== 32'h0 || rd_ready[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_p41: data=%h ready=%b want 0/0", rd_data[32 +: 32], rd_ready[1]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rd_index = '0;
        idle_inputs();
        test_reset();
        test_alloc_write();
        test_preg0();
        test_same_cycle();
        test_dbl_write();
        test_bypass_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
